tile_obi_data_router: RTL
=========================

Name: tile_obi_data_router

Overview:
- Routes the core's single OBI data manager port to two subordinates: idx 0 = L1 (HCI/TCDM path), idx 1 = L2 (AXI xbar path).
- Decodes each address against two rules and handles unmapped addresses with an internal error responder.
- Tracks up to N_MAX_TRAN outstanding transactions and keeps responses in order by never having two targets in flight at once.
- Sits between the CV32E40X data port and the HCI / OBI-to-AXI bridges inside the RedMulE tile.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8
- AID_W, 1, OBI aid/rid width
- N_MAX_TRAN, 1, maximum outstanding transactions (≥1)
- L1_START, 32'h1000_0000, rule 0 start (inclusive)
- L1_END, 32'h2000_0000, rule 0 end (exclusive)
- L2_START, 32'h2000_0000, rule 1 start (inclusive)
- L2_END, 32'h3000_0000, rule 1 end (exclusive)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- mgr_req_i  in  1  manager request
- mgr_gnt_o  out  1  grant to manager
- mgr_addr_i  in  ADDR_W  address
- mgr_we_i  in  1  write enable
- mgr_be_i  in  BE_W  byte enables
- mgr_wdata_i  in  DATA_W  write data
- mgr_aid_i  in  AID_W  transaction id
- mgr_rvalid_o  out  1  response valid
- mgr_rdata_o  out  DATA_W  response data
- mgr_rid_o  out  AID_W  response id
- mgr_err_o  out  1  response error
- sbr_req_o  out  2  per-subordinate request (one-hot or zero)
- sbr_gnt_i  in  2  per-subordinate grant
- sbr_addr_o  out  ADDR_W  broadcast address
- sbr_we_o  out  1  broadcast write enable
- sbr_be_o  out  BE_W  broadcast byte enables
- sbr_wdata_o  out  DATA_W  broadcast write data
- sbr_aid_o  out  AID_W  broadcast id
- sbr_rvalid_i  in  2  per-subordinate response valid
- sbr_rdata_i  in  2*DATA_W  response data; [DATA_W-1:0] = sbr 0
- sbr_rid_i  in  2*AID_W  response ids
- sbr_err_i  in  2  response errors
- spurious_rsp_o  out  1  pulse: response received from a subordinate with nothing outstanding to it

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is synchronous and active-low.
- Reset effects: outstanding counter cnt_q=0, target register tgt_q=0, error-pending register err_q=0.
- Outputs during and after reset:
  - All registered outputs (spurious_rsp_o, error response fields) are 0 during reset and in the first cycle after reset.
  - All combinational outputs are 0 whenever mgr_req_i=0 and no response is arriving.
- Decode (combinational):
  - sel = 0 if L1_START ≤ addr < L1_END.
  - Else sel = 1 if L2_START ≤ addr < L2_END.
  - Else sel = ERR. Rule 0 wins on overlap.
- Request-path stall: stall = (cnt_q == N_MAX_TRAN) || (cnt_q != 0 && sel != tgt_q) || (sel == ERR && cnt_q != 0).
- Forwarding to a subordinate (sel ∈ {0,1}, no stall):
  - sbr_req_o[sel] = mgr_req_i; mgr_gnt_o = sbr_gnt_i[sel].
  - Payload is broadcast unchanged, combinationally. Zero added latency on the request path.
- Unmapped address (sel = ERR, no stall):
  - mgr_gnt_o = 1 and no sbr_req_o asserted.
  - err_q is set and the aid is captured.
  - Next cycle: mgr_rvalid_o=1, mgr_err_o=1, mgr_rdata_o=0, mgr_rid_o = captured aid; err_q then clears.
  - Throughput for errors: 1 per 2 cycles.
- While stalled: sbr_req_o=0 and mgr_gnt_o=0. The manager must hold its request stable (OBI rule).
- Accept: mgr_req_i && mgr_gnt_o. On accept, tgt_q ← sel (ERR encoded separately) and cnt_q increments.
- Response path:
  - A response is routed from tgt_q when cnt_q>0: mgr_rvalid_o = sbr_rvalid_i[tgt_q], with rdata, rid and err muxed from the same subordinate. Zero latency.
  - Each response decrements cnt_q.
  - Accept and response in the same cycle leave cnt_q unchanged.
- Spurious responses:
  - A sbr_rvalid_i[k] where k != tgt_q, or where cnt_q == 0, is dropped (not forwarded).
  - spurious_rsp_o pulses for 1 cycle, registered, so it appears the cycle after the stray response.
- Back-to-back switching: a target switch is permitted in the same cycle that the last outstanding response arrives? No. The stall term uses cnt_q, so a switch happens one cycle after cnt_q reaches 0.
- Reset mid-operation: all state clears. Responses that arrive later for pre-reset transactions count as spurious and are not forwarded.
- RTL assertions:
  - cnt_q never exceeds N_MAX_TRAN and never underflows.
  - sbr_req_o is onehot0.

Test Plan:
- Read at 0x1000_0040 with sbr 0 granting at once and responding 1 cycle later with rdata=0xDEADBEEF → sbr_req_o=2'b01; mgr_gnt_o in the same cycle; mgr_rvalid_o with 0xDEADBEEF and err=0; cnt returns to 0.
- Write at 0x2000_0100, be=4'b0011, with sbr 1 holding gnt low for 3 cycles → sbr_req_o=2'b10 held 3 cycles; mgr_gnt_o low until sbr_gnt_i[1]; payload matches the input.
- Access to 0x0000_1000 with aid=1 → gnt in the same cycle; the next cycle gives rvalid=1, err=1, rdata=0, rid=1; neither subordinate requested.
- N_MAX_TRAN=2: L1 read, then L2 read while the L1 response is pending → the L2 request stalls until the cycle after the L1 response. Then L1, L1, L1 with no responses → the third request stalls at cnt=2.
- sbr_rvalid_i[1] pulsed while cnt=0 → mgr_rvalid_o stays 0; spurious_rsp_o=1 the next cycle.
- rst_ni low for 1 cycle with 1 outstanding L1 read → the following sbr_rvalid_i[0] is not forwarded and is flagged spurious; a new L2 request is accepted immediately.

Source files
------------

// File: rtl/tile_obi_data_router.sv
// OBI data router for the RedMulE tile: one core manager port to L1 (idx 0)
// and L2 (idx 1), with an in-order outstanding tracker and an error responder.
module tile_obi_data_router #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AID_W = 1,
  parameter int unsigned N_MAX_TRAN = 1,
  parameter logic [ADDR_W-1:0] L1_START = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] L1_END = 32'h2000_0000,
  parameter logic [ADDR_W-1:0] L2_START = 32'h2000_0000,
  parameter logic [ADDR_W-1:0] L2_END = 32'h3000_0000,
  localparam int unsigned BE_W = DATA_W / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mgr_req_i,
  output logic                  mgr_gnt_o,
  input  logic [ADDR_W-1:0]     mgr_addr_i,
  input  logic                  mgr_we_i,
  input  logic [BE_W-1:0]       mgr_be_i,
  input  logic [DATA_W-1:0]     mgr_wdata_i,
  input  logic [AID_W-1:0]      mgr_aid_i,
  output logic                  mgr_rvalid_o,
  output logic [DATA_W-1:0]     mgr_rdata_o,
  output logic [AID_W-1:0]      mgr_rid_o,
  output logic                  mgr_err_o,
  output logic [1:0]            sbr_req_o,
  input  logic [1:0]            sbr_gnt_i,
  output logic [ADDR_W-1:0]     sbr_addr_o,
  output logic                  sbr_we_o,
  output logic [BE_W-1:0]       sbr_be_o,
  output logic [DATA_W-1:0]     sbr_wdata_o,
  output logic [AID_W-1:0]      sbr_aid_o,
  input  logic [1:0]            sbr_rvalid_i,
  input  logic [2*DATA_W-1:0]   sbr_rdata_i,
  input  logic [2*AID_W-1:0]    sbr_rid_i,
  input  logic [1:0]            sbr_err_i,
  output logic                  spurious_rsp_o
);

  localparam int unsigned CNT_W = $clog2(N_MAX_TRAN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_MAX_TRAN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_q;
  logic             err_q;
  logic             spur_q;
  logic [AID_W-1:0] aid_q;

  logic in_l1, in_l2, sel, sel_err;
  logic busy, stall, acc_sbr, acc_err, rsp, stray;
  logic [1:0] exp_rv;

  assign in_l1 = (mgr_addr_i >= L1_START) && (mgr_addr_i < L1_END);
  assign in_l2 = (mgr_addr_i >= L2_START) && (mgr_addr_i < L2_END);
  assign sel = !in_l1;
  assign sel_err = !in_l1 && !in_l2;

  assign busy = (cnt_q != '0);
  // err_q also blocks, so error responses never overlap a new accept
  assign stall = (cnt_q == CNT_MAX)
              || (busy && !sel_err && (sel != tgt_q))
              || (busy && sel_err)
              || err_q;

  always_comb begin
    sbr_req_o = 2'b00;
    mgr_gnt_o = 1'b0;
    if (mgr_req_i && !stall) begin
      if (sel_err) begin
        mgr_gnt_o = 1'b1;
      end else begin
        sbr_req_o[sel] = 1'b1;
        mgr_gnt_o = sbr_gnt_i[sel];
      end
    end
  end

  assign sbr_addr_o = mgr_req_i ? mgr_addr_i : '0;
  assign sbr_we_o = mgr_req_i & mgr_we_i;
  assign sbr_be_o = mgr_req_i ? mgr_be_i : '0;
  assign sbr_wdata_o = mgr_req_i ? mgr_wdata_i : '0;
  assign sbr_aid_o = mgr_req_i ? mgr_aid_i : '0;

  assign acc_sbr = mgr_req_i && mgr_gnt_o && !sel_err;
  assign acc_err = mgr_req_i && mgr_gnt_o && sel_err;
  assign rsp = busy && sbr_rvalid_i[tgt_q];

  assign exp_rv = busy ? (tgt_q ? 2'b10 : 2'b01) : 2'b00;
  assign stray = |(sbr_rvalid_i & ~exp_rv);

  always_comb begin
    mgr_rvalid_o = 1'b0;
    mgr_rdata_o = '0;
    mgr_rid_o = '0;
    mgr_err_o = 1'b0;
    if (err_q) begin
      mgr_rvalid_o = 1'b1;
      mgr_rid_o = aid_q;
      mgr_err_o = 1'b1;
    end else if (rsp) begin
      mgr_rvalid_o = 1'b1;
      mgr_rdata_o = tgt_q ? sbr_rdata_i[2*DATA_W-1:DATA_W]
                          : sbr_rdata_i[DATA_W-1:0];
      mgr_rid_o = tgt_q ? sbr_rid_i[2*AID_W-1:AID_W]
                        : sbr_rid_i[AID_W-1:0];
      mgr_err_o = sbr_err_i[tgt_q];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (acc_sbr && !rsp) cnt_d = cnt_q + CNT_W'(1);
    else if (!acc_sbr && rsp) cnt_d = cnt_q - CNT_W'(1);
  end

  assign spurious_rsp_o = spur_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tgt_q <= 1'b0;
      err_q <= 1'b0;
      spur_q <= 1'b0;
      aid_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (acc_sbr) tgt_q <= sel;
      err_q <= acc_err;
      if (acc_err) aid_q <= mgr_aid_i;
      spur_q <= stray;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (cnt_q <= CNT_MAX);
      assert (!(rsp && !busy));
      assert ($onehot0(sbr_req_o));
    end
  end
`endif

endmodule
